// File: rtl/lstm_seq_ctrl.sv
// lstm_seq_ctrl: per-timestep sequencer feeding a combinational LSTM cell and streaming h_out
module lstm_seq_ctrl #(
   parameter int W      = 16,
   parameter int SETTLE = 2,
   parameter int LEN_W  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [LEN_W-1:0] seq_len_i,
   input  logic             abort_i,
   input  logic             x_valid_i,
   input  logic [W-1:0]     x_data_i,
   output logic             x_ready_o,
   output logic [W-1:0]     cell_x_o,
   output logic [W-1:0]     cell_c_in_o,
   output logic [W-1:0]     cell_h_in_o,
   input  logic [W-1:0]     cell_c_out_i,
   input  logic [W-1:0]     cell_h_out_i,
   output logic             y_valid_o,
   output logic [W-1:0]     y_data_o,
   output logic             y_last_o,
   input  logic             y_ready_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [W-1:0]     c_final_o,
   output logic [W-1:0]     h_final_o
);
   localparam int CNT_W = 4;
   typedef enum logic [2:0] {S_IDLE, S_WAIT_X, S_SETTLE, S_EMIT, S_DONE} state_t;
   state_t           state_q, state_d;
   logic [W-1:0]     x_q, c_q, h_q, yd_q, cf_q, hf_q;
   logic [LEN_W-1:0] len_q, step_q;
   logic [CNT_W-1:0] cnt_q;
   logic             yl_q, zl_q;
   logic             go, x_hs, cap, y_hs;
   assign go   = state_q == S_IDLE && start_i && seq_len_i != '0;
   assign x_hs = state_q == S_WAIT_X && x_valid_i && !abort_i;
   assign cap  = state_q == S_SETTLE && cnt_q == '0 && !abort_i;
   assign y_hs = state_q == S_EMIT && y_ready_i && !abort_i;
   assign cell_x_o    = x_q;
   assign cell_c_in_o = c_q;
   assign cell_h_in_o = h_q;
   assign y_data_o    = yd_q;
   assign y_last_o    = yl_q;
   assign c_final_o   = cf_q;
   assign h_final_o   = hf_q;
   // state register
   always_ff @(posedge clk) state_q <= rst ? S_IDLE : state_d;
   // next-state: abort from any active state overrides every handshake
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (go) state_d = S_WAIT_X;
         S_WAIT_X: if (x_valid_i) state_d = S_SETTLE;
         S_SETTLE: if (cnt_q == '0) state_d = S_EMIT;
         S_EMIT:   if (y_ready_i) state_d = yl_q ? S_DONE : S_WAIT_X;
         S_DONE:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
      if (abort_i && state_q != S_IDLE) state_d = S_IDLE;
   end
   // outputs decoded from state; zero-length starts pulse done without leaving IDLE
   always_comb begin
      x_ready_o = state_q == S_WAIT_X;
      y_valid_o = state_q == S_EMIT;
      busy_o    = state_q != S_IDLE;
      done_o    = state_q == S_DONE || zl_q;
   end
   // datapath: sample, settle countdown, bit-exact capture of the cell results
   always_ff @(posedge clk) begin
      if (rst) begin
         x_q <= '0; c_q <= '0; h_q <= '0; yd_q <= '0; cf_q <= '0; hf_q <= '0;
         len_q <= '0; step_q <= '0; cnt_q <= '0; yl_q <= 1'b0; zl_q <= 1'b0;
      end else begin
         zl_q <= state_q == S_IDLE && start_i && seq_len_i == '0;
         if (go) begin
            c_q    <= '0;
            h_q    <= '0;
            len_q  <= seq_len_i;
            step_q <= '0;
         end
         if (x_hs) begin
            x_q   <= x_data_i;
            cnt_q <= CNT_W'(SETTLE - 1);
         end else if (state_q == S_SETTLE && cnt_q != '0 && !abort_i) begin
            cnt_q <= cnt_q - CNT_W'(1);
         end
         if (cap) begin
            c_q  <= cell_c_out_i;
            h_q  <= cell_h_out_i;
            yd_q <= cell_h_out_i;
            yl_q <= step_q == len_q - LEN_W'(1);
            cf_q <= cell_c_out_i;
            hf_q <= cell_h_out_i;
         end
         if (y_hs) step_q <= step_q + LEN_W'(1);
      end
   end
endmodule

// File: doc/lstm_seq_ctrl.md
# lstm_seq_ctrl

Sequential controller that runs the combinational LSTM cell over a time series of Q8.8 input samples. It accepts X samples on a valid/ready stream and drives the cell's X/c_in/h_in inputs from registers. After a fixed settle window it captures c_out/h_out back as recurrent state and emits each h_out on a valid/ready output stream. It replaces hand-driven stimulus with a synthesizable per-timestep sequencer that sits between the sample source and the cell.

## Interface
- W, 16, data width of X, c, h (signed Q8.8)
- SETTLE, 2, cycles the cell inputs are held stable before capture; legal range 1..15
- LEN_W, 8, width of the sequence-length field

- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset: one clock; reset is synchronous and active-high
- start  in  1  begin a sequence; sampled only in IDLE
- seq_len  in  LEN_W  number of timesteps; latched on accepted start
- abort  in  1  synchronous abort; returns to IDLE, no done pulse
- x_valid  in  1  input sample valid
- x_data  in  W  input sample X, signed Q8.8
- x_ready  out  1  controller can accept a sample
- cell_x, cell_c_in, cell_h_in  out  W each  registered drive to cell X, c_in, h_in
- cell_c_out, cell_h_out  in  W each  cell results
- y_valid  out  1  output sample valid
- y_data  out  W  h_out for the current timestep
- y_last  out  1  qualifies the final timestep of the sequence
- y_ready  in  1  downstream accepts y
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last y handshake
- c_final, h_final  out  W each  state after the most recent completed step; held until next start

## Operation
- States: IDLE, WAIT_X, SETTLE, EMIT, DONE.
- IDLE: start=1 with seq_len≠0 clears c_reg and h_reg to 0, latches seq_len, sets step=0, and moves to WAIT_X. start=1 with seq_len=0 pulses done the next cycle and stays in IDLE; the state registers are untouched.
- WAIT_X: x_ready=1. When x_valid&&x_ready, x_data goes to x_reg, the settle counter loads SETTLE-1, and the FSM moves to SETTLE.
- SETTLE: cell_x=x_reg, cell_c_in=c_reg, cell_h_in=h_reg, all stable. The counter decrements each cycle. On the cycle it reads 0:
  - c_reg<=cell_c_out, h_reg<=cell_h_out, y_data<=cell_h_out;
  - y_last<=(step==seq_len-1);
  - c_final/h_final update; go to EMIT.
- EMIT: y_valid=1. y_data and y_last are held until y_ready. On handshake step increments. If y_last, go to DONE; otherwise go to WAIT_X.
- DONE: done=1 for exactly one cycle, then IDLE.
- No arithmetic in the block. Values are captured bit-exact, with no saturation or rescaling; the cell owns the Q8.8 semantics.
- start in any non-IDLE state is ignored.
- abort in any state except IDLE goes to IDLE next cycle. y_valid, x_ready and done go low, and c_final/h_final keep their last completed values. abort has priority over every handshake in the same cycle.
- rst has priority over abort and start.

## Timing
- Reset values:
  - all state registers, cell_* outputs, y_data, c_final and h_final = 0;
  - x_ready, y_valid, y_last, busy and done = 0;
  - FSM = IDLE.
- start accepted at edge T: busy=1 and x_ready=1 from cycle T+1.
- x handshake at edge T: cell inputs carry the new sample from T+1 and stay stable for SETTLE cycles. State is captured at edge T+SETTLE, and y_valid=1 from T+SETTLE+1. Minimum latency from x handshake to y_valid is SETTLE+1 cycles.
- x_ready is low from the x handshake until the y handshake, so there is one sample in flight.
- For a non-last y handshake at edge T, x_ready=1 at T+1. Best-case throughput is one sample per SETTLE+2 cycles.
- The last y handshake at edge T gives done=1 during T+1 and IDLE with busy=0 at T+2.
- y_valid never deasserts without a handshake, except on abort or rst.

## Test plan
Cell stub for all tests: c_out = c_in + X, h_out = c_in + X, both truncated to 16 bits.
- Reset: rst high for 2 cycles with x_valid=1 and start=1. All outputs are 0, the FSM stays in IDLE, and x_ready=0.
- Basic sequence with SETTLE=2: seq_len=3, X=0x0100, 0x0080, 0xFF80, y_ready=1. Required results:
  - y_data=0x0100, 0x0180, 0x0100;
  - y_last only on the third sample;
  - y_valid exactly 3 cycles after each x handshake;
  - done pulse one cycle after the third handshake;
  - c_final=h_final=0x0100.
- Backpressure: y_ready held low for 5 cycles on step 1. y_data and y_valid stay stable and x_ready stays 0; step 2 proceeds normally after release.
- Zero length: start with seq_len=0. done pulses one cycle later, busy never rises, and x_ready stays 0.
- Abort mid-SETTLE on step 2 of 3: IDLE on the next cycle with no done. c_final=0x0100 from step 1. A new start restarts from c=h=0.
- Wrap: seq_len=255 with X=0x7F00 every step. c wraps modulo 2^16 exactly as the stub produces it, and y_last is asserted only at step 254.
